// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester round-robin write-back arbiter driving a single
// register-file write port, with a per-register pending-write scoreboard.
// Register 0 is hard-wired: writes to it are accepted but never issued, and
// it is never marked pending.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [AW-1:0]     s0_addr,
    input  logic [DW-1:0]     s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [AW-1:0]     s1_addr,
    input  logic [DW-1:0]     s1_data,
    output logic              s1_ready,
    output logic              we3,
    output logic [AW-1:0]     wa3,
    output logic [DW-1:0]     wd3,
    input  logic              busy_set,
    input  logic [AW-1:0]     busy_set_addr,
    output logic [2**AW-1:0]  busy
);

    // Priority pointer: 0 favours s0, 1 favours s1.
    logic              ptr_r;
    logic              grant0_s;
    logic              grant1_s;
    logic              hs_s;
    logic [AW-1:0]     hs_addr_s;
    logic [DW-1:0]     hs_data_s;
    logic              wr_s;
    logic [2**AW-1:0]  busy_next_s;

    // Arbitration: a lone requester always wins; under contention the pointer decides.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (s0_valid && (!s1_valid || !ptr_r)) begin
            grant0_s = 1'b1;
        end else if (s1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign s0_ready = grant0_s;
    assign s1_ready = grant1_s;

    // Select the winning request and decide whether it produces a real write.
    always_comb begin
        hs_s      = grant0_s | grant1_s;
        hs_addr_s = {AW{1'b0}};
        hs_data_s = {DW{1'b0}};
        if (grant1_s) begin
            hs_addr_s = s1_addr;
            hs_data_s = s1_data;
        end else begin
            hs_addr_s = s0_addr;
            hs_data_s = s0_data;
        end
        wr_s = hs_s && (hs_addr_s != {AW{1'b0}});
    end

    // Scoreboard update: clear on write-back, then set, so a same-edge set wins.
    always_comb begin
        busy_next_s = busy;
        if (wr_s) begin
            busy_next_s[hs_addr_s] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (busy_set && (busy_set_addr != {AW{1'b0}})) begin
            busy_next_s[busy_set_addr] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
        busy_next_s[0] = 1'b0;
    end

    // Registered write port, pointer and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3   <= 1'b0;
            wa3   <= {AW{1'b0}};
            wd3   <= {DW{1'b0}};
            ptr_r <= 1'b0;
            busy  <= {(2**AW){1'b0}};
        end else begin
            we3  <= wr_s;
            busy <= busy_next_s;
            if (wr_s) begin
                wa3 <= hs_addr_s;
                wd3 <= hs_data_s;
            end
            // After a grant, favour the requester that did not win.
            if (hs_s) begin
                ptr_r <= grant0_s;
            end
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of write-back data and register-file write port.
REQ-002 Parameter: AW, 5, register address width (2**AW registers).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s0_valid  input  1  requester 0 (ALU write-back) has a write pending.
REQ-006 s0_addr  input  AW  requester 0 destination register.
REQ-007 s0_data  input  DW  requester 0 write data.
REQ-008 s0_ready  output  1  requester 0 write accepted this cycle.
REQ-009 s1_valid  input  1  requester 1 (load unit) has a write pending.
REQ-010 s1_addr  input  AW  requester 1 destination register.
REQ-011 s1_data  input  DW  requester 1 write data.
REQ-012 s1_ready  output  1  requester 1 write accepted this cycle.
REQ-013 we3  output  1  register-file write enable, registered.
REQ-014 wa3  output  AW  register-file write address, registered.
REQ-015 wd3  output  DW  register-file write data, registered.
REQ-016 busy_set  input  1  issue stage marks a register as pending write.
REQ-017 busy_set_addr  input  AW  register to mark pending.
REQ-018 busy  output  2**AW  scoreboard, bit n = register n has a write outstanding.

Function
REQ-019 The block SHALL grant at most one requester per cycle; handshake = sX_valid && sX_ready on a rising edge.
REQ-020 sX_ready SHALL be combinational: high only for the granted requester, and only while its sX_valid is high.
REQ-021 Arbitration SHALL be round-robin via a 1-bit priority pointer: pointer=0 favours s0, pointer=1 favours s1.
REQ-022 Only one valid: that requester SHALL be granted regardless of pointer.
REQ-023 Pointer SHALL flip to the other requester after every handshake; it SHALL be unchanged in cycles with no handshake.
REQ-024 Both valid continuously: grants SHALL alternate s0, s1, s0, ... (no starvation; max wait 1 cycle).
REQ-025 Requesters SHALL hold valid/addr/data stable until handshake; the block SHALL sample addr/data only at handshake.
REQ-026 Handshake with addr != 0: the next cycle SHALL present we3=1, wa3=addr, wd3=data (latency exactly 1 cycle).
REQ-027 Handshake with addr == 0: SHALL complete (ready high), and next cycle we3 SHALL be 0; wa3/wd3 don't-care.
REQ-028 No handshake: we3 SHALL be 0 in the following cycle; wa3/wd3 SHALL hold their previous values.
REQ-029 Throughput SHALL be one write per cycle; back-to-back handshakes SHALL produce back-to-back we3 pulses.
REQ-030 busy_set with busy_set_addr != 0 SHALL set busy[busy_set_addr] at the next edge.
REQ-031 A handshake with addr != 0 SHALL clear busy[addr] at the same edge that registers we3 (busy low when we3 high).
REQ-032 Set and clear of the same register at the same edge: set SHALL win (new pending write).
REQ-033 busy[0] SHALL be 0 at all times; busy_set to address 0 SHALL be ignored.
REQ-034 Clearing a bit that is not set SHALL be harmless (bit stays 0); setting a set bit SHALL leave it 1.
REQ-035 Writes from both requesters to the same address in successive cycles SHALL reach we3 in grant order.

Reset
REQ-036 Asserting rst SHALL immediately force we3=0, wa3=0, wd3=0, busy=0, pointer=0, independent of clk.
REQ-037 While rst is high, s0_ready and s1_ready SHALL be 0 and no handshake SHALL occur.
REQ-038 A handshake in flight when rst asserts SHALL be discarded; no we3 pulse SHALL follow reset release.
REQ-039 The first cycle after rst deassertion with both valid SHALL grant s0.

Verification
REQ-040 Reset: rst pulse mid-cycle with s0_valid=1 -> we3=0, busy=0 immediately; after release s0 granted first.
REQ-041 Single: s0_valid, addr=5, data=0xDEADBEEF -> s0_ready=1 that cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF.
REQ-042 Contention: both valid 4 cycles, s0 addr=1, s1 addr=2 -> grants s0,s1,s0,s1; wa3 sequence 1,2,1,2 one cycle later.
REQ-043 Zero register: s1_valid, addr=0 -> s1_ready=1; next cycle we3=0; busy[0] stays 0.
REQ-044 Scoreboard: busy_set addr=7 -> busy[7]=1; later s1 handshake addr=7 -> busy[7]=0 when we3=1, wa3=7.
REQ-045 Collision: busy_set addr=9 and s0 handshake addr=9 in same cycle with busy[9]=1 -> busy[9] remains 1.
